// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: IR/CON feedback in,
// bus selects, register enables, memory strobes and ALU op out.
interface control_sequencer_if #(
  parameter int unsigned OPW = 5
) ();
  logic [31:0]    IR;
  logic           CON_FF;
  logic           PCout, Zhighout, Zlowout, MDRout, Cout, BAout;
  logic           Gra, Grb, Grc, Rin, Rout;
  logic           PCin, MARin, MDRin, IRin, Yin, Zhighin, Zlowin, CONin, IncPC;
  logic           Read, Write;
  logic [OPW-1:0] op;
  logic           Run;

  modport master (
    input  IR, CON_FF,
    output PCout, Zhighout, Zlowout, MDRout, Cout, BAout,
           Gra, Grb, Grc, Rin, Rout,
           PCin, MARin, MDRin, IRin, Yin, Zhighin, Zlowin, CONin, IncPC,
           Read, Write, op, Run
  );

  modport slave (
    output IR, CON_FF,
    input  PCout, Zhighout, Zlowout, MDRout, Cout, BAout,
           Gra, Grb, Grc, Rin, Rout,
           PCin, MARin, MDRin, IRin, Yin, Zhighin, Zlowin, CONin, IncPC,
           Read, Write, op, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, then per-class execute steps.
// The instruction class is latched from IR on the T2->T3 edge.
module control_sequencer #(
  parameter int unsigned    OPW    = 5,
  parameter logic [OPW-1:0] ADD_OP = OPW'(5'b00011)
) (
  input logic                   Clock,
  input logic                   clear_n,
  control_sequencer_if.master   bus
);

  typedef enum logic [3:0] {
    StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } step_e;

  typedef enum logic [3:0] {
    ClsNop, ClsAlu, ClsImm, ClsLd, ClsSt, ClsJr, ClsJal, ClsBr, ClsHalt
  } cls_e;

  step_e          step_q, step_d, last_step;
  cls_e           cls_q, cls_d;
  logic [OPW-1:0] op_q, op_d;

  function automatic cls_e decode(input logic [4:0] opc);
    case (opc)
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000: decode = ClsAlu;
      5'b01001, 5'b00001:           decode = ClsImm;
      5'b00000:                     decode = ClsLd;
      5'b00010:                     decode = ClsSt;
      5'b10011:                     decode = ClsJr;
      5'b10100:                     decode = ClsJal;
      5'b10010:                     decode = ClsBr;
      5'b11011:                     decode = ClsHalt;
      default:                      decode = ClsNop;
    endcase
  endfunction

  always_comb begin
    case (cls_q)
      ClsAlu, ClsImm: last_step = StT5;
      ClsLd, ClsSt:   last_step = StT7;
      ClsJal:         last_step = StT4;
      ClsBr:          last_step = StT6;
      default:        last_step = StT3;
    endcase
  end

  always_comb begin
    step_d = step_q;
    cls_d  = cls_q;
    op_d   = op_q;
    unique case (step_q)
      StT0:   step_d = StT1;
      StT1:   step_d = StT2;
      StT2: begin
        cls_d  = decode(bus.IR[31:27]);
        op_d   = OPW'(bus.IR[31:27]);
        step_d = (cls_d == ClsNop) ? StT0 : StT3;
      end
      StHalt: step_d = StHalt;
      default: begin
        if (step_q == last_step) step_d = (cls_q == ClsHalt) ? StHalt : StT0;
        else                     step_d = step_e'(step_q + 4'd1);
      end
    endcase
  end

  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      step_q <= StT0;
      cls_q  <= ClsNop;
      op_q   <= '0;
    end else begin
      step_q <= step_d;
      cls_q  <= cls_d;
      op_q   <= op_d;
    end
  end

  // Outputs are gated by clear_n so an aborted instruction strobes nothing.
  always_comb begin
    bus.PCout = 1'b0; bus.Zhighout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0;
    bus.Cout  = 1'b0; bus.BAout    = 1'b0;
    bus.Gra   = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.PCin  = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
    bus.Zhighin = 1'b0; bus.Zlowin = 1'b0; bus.CONin = 1'b0; bus.IncPC = 1'b0;
    bus.Read  = 1'b0; bus.Write = 1'b0;
    bus.op    = '0;
    bus.Run   = clear_n && (step_q != StHalt);
    if (clear_n) begin
      unique case (step_q)
        StT0: begin
          bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1;
          bus.Zhighin = 1'b1; bus.Zlowin = 1'b1;
        end
        StT1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
        StT2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
        StT3: begin
          unique case (cls_q)
            ClsAlu: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
            ClsImm, ClsLd, ClsSt: begin
              bus.Grb = 1'b1; bus.Rout = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
            end
            ClsJr:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
            ClsJal: begin bus.PCout = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1; end
            ClsBr:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
            default: ;
          endcase
        end
        StT4: begin
          unique case (cls_q)
            ClsAlu: begin
              bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zhighin = 1'b1; bus.Zlowin = 1'b1;
              bus.op  = op_q;
            end
            ClsImm, ClsLd, ClsSt: begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; bus.op = ADD_OP; end
            ClsJal: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
            ClsBr:  begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
            default: ;
          endcase
        end
        StT5: begin
          unique case (cls_q)
            ClsAlu, ClsImm: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            ClsLd, ClsSt:   begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
            ClsBr:          begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; bus.op = ADD_OP; end
            default: ;
          endcase
        end
        StT6: begin
          unique case (cls_q)
            ClsLd: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
            ClsSt: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
            ClsBr: begin bus.Zlowout = bus.CON_FF; bus.PCin = bus.CON_FF; end
            default: ;
          endcase
        end
        StT7: begin
          unique case (cls_q)
            ClsLd: begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            ClsSt: bus.Write = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: each instruction's step list is built from the opcode
// table and compared against the DUT on every falling edge.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic clear_n;
  always #5 Clock = ~Clock;

  control_sequencer_if #(.OPW(5)) bus ();
  control_sequencer #(.OPW(5), .ADD_OP(5'b00011)) dut (
    .Clock   (Clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  localparam logic [21:0] M_PCOUT = 22'(1) << 21, M_ZHOUT = 22'(1) << 20,
                          M_ZLOUT = 22'(1) << 19, M_MDROUT = 22'(1) << 18,
                          M_COUT  = 22'(1) << 17, M_BAOUT = 22'(1) << 16,
                          M_GRA   = 22'(1) << 15, M_GRB = 22'(1) << 14,
                          M_GRC   = 22'(1) << 13, M_RIN = 22'(1) << 12,
                          M_ROUT  = 22'(1) << 11, M_PCIN = 22'(1) << 10,
                          M_MARIN = 22'(1) << 9,  M_MDRIN = 22'(1) << 8,
                          M_IRIN  = 22'(1) << 7,  M_YIN = 22'(1) << 6,
                          M_ZHIN  = 22'(1) << 5,  M_ZLIN = 22'(1) << 4,
                          M_CONIN = 22'(1) << 3,  M_INCPC = 22'(1) << 2,
                          M_READ  = 22'(1) << 1,  M_WRITE = 22'(1);
  localparam logic [4:0] ADD = 5'b00011;

  logic [27:0] act, exp_v;
  logic        exp_valid;
  logic [27:0] seq[$];
  int          n_checks = 0;
  int          n_errors = 0;

  assign act = {bus.Run, bus.op, bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.Cout,
                bus.BAout, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.PCin, bus.MARin,
                bus.MDRin, bus.IRin, bus.Yin, bus.Zhighin, bus.Zlowin, bus.CONin, bus.IncPC,
                bus.Read, bus.Write};

  task automatic chk(input string name, input logic [27:0] got, input logic [27:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [27:0] stp(input logic [4:0] op, input logic [21:0] c);
    return {1'b1, op, c};
  endfunction

  // Step list of one instruction, straight from the opcode table.
  task automatic build_seq(input logic [4:0] opc, input logic con);
    seq.delete();
    seq.push_back(stp(5'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZHIN | M_ZLIN));
    seq.push_back(stp(5'd0, M_ZLOUT | M_PCIN | M_READ | M_MDRIN));
    seq.push_back(stp(5'd0, M_MDROUT | M_IRIN));
    if (opc >= 5'd3 && opc <= 5'd8) begin
      seq.push_back(stp(5'd0, M_GRB | M_ROUT | M_YIN));
      seq.push_back(stp(opc, M_GRC | M_ROUT | M_ZHIN | M_ZLIN));
      seq.push_back(stp(5'd0, M_ZLOUT | M_GRA | M_RIN));
    end else if (opc == 5'd9 || opc == 5'd1 || opc == 5'd0 || opc == 5'd2) begin
      seq.push_back(stp(5'd0, M_GRB | M_ROUT | M_BAOUT | M_YIN));
      seq.push_back(stp(ADD, M_COUT | M_ZLIN));
      if (opc == 5'd9 || opc == 5'd1) begin
        seq.push_back(stp(5'd0, M_ZLOUT | M_GRA | M_RIN));
      end else begin
        seq.push_back(stp(5'd0, M_ZLOUT | M_MARIN));
        if (opc == 5'd0) begin
          seq.push_back(stp(5'd0, M_READ | M_MDRIN));
          seq.push_back(stp(5'd0, M_MDROUT | M_GRA | M_RIN));
        end else begin
          seq.push_back(stp(5'd0, M_GRA | M_ROUT | M_MDRIN));
          seq.push_back(stp(5'd0, M_WRITE));
        end
      end
    end else if (opc == 5'd19) begin
      seq.push_back(stp(5'd0, M_GRA | M_ROUT | M_PCIN));
    end else if (opc == 5'd20) begin
      seq.push_back(stp(5'd0, M_PCOUT | M_GRB | M_RIN));
      seq.push_back(stp(5'd0, M_GRA | M_ROUT | M_PCIN));
    end else if (opc == 5'd18) begin
      seq.push_back(stp(5'd0, M_GRA | M_ROUT | M_CONIN));
      seq.push_back(stp(5'd0, M_PCOUT | M_YIN));
      seq.push_back(stp(ADD, M_COUT | M_ZLIN));
      seq.push_back(stp(5'd0, con ? (M_ZLOUT | M_PCIN) : 22'd0));
    end else if (opc == 5'd27) begin
      seq.push_back(stp(5'd0, 22'd0));
    end
  endtask

  // Entered and left at posedge+1 of a T0 cycle; IR is only valid during T2.
  task automatic do_instr(input logic [31:0] ir, input logic con, input int abort_at);
    build_seq(ir[31:27], con);
    for (int i = 0; i < seq.size(); i++) begin
      exp_v      = seq[i];
      bus.IR     = (i == 2) ? ir : $urandom;
      bus.CON_FF = (ir[31:27] == 5'd18 && i == 6) ? con : 1'($urandom);
      if (i == abort_at) begin
        clear_n = 1'b0;
        exp_v   = '0;
        #1 chk("async_clear", act, 28'h0);
        @(posedge Clock);
        #1 clear_n = 1'b1;
        break;
      end
      @(posedge Clock);
      #1;
    end
  endtask

  always @(negedge Clock) begin
    if (exp_valid) chk("cycle", act, exp_v);
  end

  initial begin
    clear_n    = 1'b0;
    bus.IR     = '0;
    bus.CON_FF = 1'b0;
    exp_v      = '0;
    exp_valid  = 1'b1;

    // Pin the model against hand-decoded step vectors.
    build_seq(5'b00011, 1'b0);
    chk("pin_add_len", 28'(seq.size()), 28'd6);
    chk("pin_t0", seq[0], 28'h8200234);
    chk("pin_add_t4", seq[4], 28'h8C02830);
    build_seq(5'b10011, 1'b0);
    chk("pin_jr_t3", seq[3], 28'h8008C00);
    build_seq(5'b10010, 1'b0);
    chk("pin_br_len", 28'(seq.size()), 28'd7);
    chk("pin_br_t6_nc", seq[6], 28'h8000000);
    build_seq(5'b00010, 1'b0);
    chk("pin_st_t7", seq[7], 28'h8000001);

    repeat (3) @(posedge Clock);
    #1 chk("reset_idle", act, 28'h0);
    clear_n = 1'b1;

    do_instr(32'h18918000, 1'b0, -1);  // add
    do_instr(32'h9A800000, 1'b0, -1);  // jr
    do_instr(32'hA0A00000, 1'b0, -1);  // jal
    do_instr(32'h90880000, 1'b1, -1);  // br taken
    do_instr(32'h90880000, 1'b0, -1);  // br not taken
    do_instr(32'h00880010, 1'b0, -1);  // ld
    do_instr(32'h10880010, 1'b0, -1);  // st
    do_instr(32'hD0000000, 1'b0, -1);  // nop

    for (int n = 0; n < 300; n++) begin
      logic [4:0] opc;
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'd27) opc = 5'd26;
      do_instr({opc, 27'($urandom)}, 1'($urandom), -1);
    end

    do_instr(32'hD8000000, 1'b0, -1);  // halt
    exp_v = '0;
    repeat (20) @(posedge Clock);
    #1 clear_n = 1'b0;
    @(posedge Clock);
    #1 clear_n = 1'b1;
    do_instr(32'h18918000, 1'b0, 4);   // add aborted at T4
    do_instr(32'h18918000, 1'b0, -1);

    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit for the mini CPU. It generates every datapath control strobe that the stage benches currently drive by hand, stepping through fetch (T0–T2) and the per-class execute steps decoded from the IR opcode. It sits beside data_path. It drives the bus-select, register-enable, memory and ALU-op controls, and it reads back IR and the CON flip-flop.

Parameters:
OPW, 5, opcode and ALU op width (IR[31:27])
ADD_OP, 5'b00011, ALU op used for address, immediate and branch-target adds

Ports:
Clock  input  1  system clock; all state changes on the rising edge
clear_n  input  1  asynchronous, active-low reset
IR  input  32  instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
CON_FF  input  1  branch condition flip-flop from data_path (branchCompare)
PCout, Zhighout, Zlowout, MDRout, Cout, BAout  output  1 each  bus source selects
Gra, Grb, Grc, Rin, Rout  output  1 each  register-file select and enable
PCin, MARin, MDRin, IRin, Yin, Zhighin, Zlowin, CONin, IncPC  output  1 each  register load enables
Read, Write  output  1 each  memory strobes
op  output  5  ALU operation
Run  output  1  high while executing; low in reset and HALT

Behaviour:
- Moore FSM. Outputs decode only the state register, never IR or CON_FF directly, except where noted for op and the br T6 step.
- Each step lasts exactly one clock. Outputs not listed for a step are 0, and op=0.
- Async reset: while clear_n=0, state=T0, all outputs 0 (including Run), asynchronously. This applies mid-instruction too: the instruction is aborted with no partial register or memory strobes. After release, the first rising edge completes T0.

Fetch (all instructions):
- T0: PCout, MARin, IncPC, Zhighin, Zlowin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
- T3 decodes IR loaded at the end of T2.

Execute steps by opcode:
- R-type ALU, 00011..01000:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zhighin, Zlowin, op=IR[31:27].
  - T5: Zlowout, Gra, Rin.
  - Total 6 cycles.
- addi 01001 / ldi 00001:
  - T3: Grb, Rout, BAout, Yin.
  - T4: Cout, Zlowin, op=ADD_OP.
  - T5: Zlowout, Gra, Rin.
- ld 00000:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
  - Total 8 cycles.
- st 00010:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin (Read=0).
  - T7: Write.
  - Total 8 cycles.
- jr 10011:
  - T3: Gra, Rout, PCin.
  - Total 4 cycles.
- jal 10100 (link register = Rb):
  - T3: PCout, Grb, Rin.
  - T4: Gra, Rout, PCin.
  - Total 5 cycles.
- br 10010:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zlowin, op=ADD_OP.
  - T6: Zlowout and PCin, only if CON_FF=1; otherwise all outputs 0.
  - Total 7 cycles.
- nop 11010 and any unlisted opcode: return to T0 after T2. Total 3 cycles.
- halt 11011: T3 goes to HALT. HALT has all outputs 0 and Run=0, and is held until clear_n asserts.
- After the last execute step, the next state is T0.
- Run=1 in every state except HALT and reset.
- IR and CON_FF may change at any time. Only their values at the T3 decode edge and during the br T6 step matter.

Test Plan:
- Reset: hold clear_n=0 for 3 cycles -> all outputs 0 and Run=0. Release -> T0 strobes PCout, MARin, IncPC, Zhighin, Zlowin for exactly one cycle, then T1 and T2 strobes in order.
- IR=0x18918000 (add R1,R2,R3) -> from the T0 edge, 6 cycles. op=5'b00011 only in cycle 5, with Grc, Rout, Zhighin, Zlowin. Cycle 6 asserts Zlowout, Gra, Rin. Cycle 7 is T0.
- IR=0x9A800000 (jr R5) -> cycle 4 asserts Gra, Rout, PCin simultaneously. Cycle 5 is T0. jal variant (opcode 10100) -> PCout, Grb, Rin in cycle 4, then Gra, Rout, PCin in cycle 5.
- br with CON_FF=1 -> cycle 7 asserts Zlowout and PCin. Same with CON_FF=0 -> cycle 7 asserts nothing. Both return to T0 in cycle 8.
- ld, then st back-to-back -> ld cycle 7 asserts Read and MDRin. st cycle 7 asserts Gra, Rout, MDRin with Read=0, and cycle 8 asserts Write only. Write is never high in any other cycle.
- IR=0xD8000000 (halt) -> Run falls after T3 and stays low for 20 cycles with all outputs 0. Then pulse clear_n low during an add at T4 -> outputs clear immediately, and fetch restarts at T0 after release.
